// File: rtl/wb_rr_arbiter.sv
// Two-master Wishbone classic round-robin arbiter with a tenure-long grant.
// Optional bus-timeout watchdog, enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
)(
  input  logic          clk,
  input  logic          RESET_N,
  input  logic          m0_cyc,
  input  logic          m0_stb,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  output logic          m0_err,
  input  logic          m1_cyc,
  input  logic          m1_stb,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic          m1_err,
  output logic          s_cyc,
  output logic          s_stb,
  output logic          s_we,
  output logic [AW-1:0] s_adr,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_ack,
  output logic [1:0]    grant,
  output logic [7:0]    err_cnt
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
    $error("wb_rr_arbiter: TIMEOUT must be 2..255");
  end

  // Encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t state;
  logic   last;
  logic   own0;
  logic   own1;
  logic   leave;
  logic   kill;
  logic   cyc_sel;
  logic   stb_sel;

  // Arbitration FSM; last points at the previous owner so the other wins ties.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (m0_cyc && (!m1_cyc || last))
            state <= GNT0;
          else if (m1_cyc)
            state <= GNT1;
        end
        GNT0: begin
          if (!m0_cyc) begin
            state <= IDLE;
            last  <= 1'b0;
          end
        end
        GNT1: begin
          if (!m1_cyc) begin
            state <= IDLE;
            last  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign grant = state;
  assign own0  = (state == GNT0);
  assign own1  = (state == GNT1);
  assign leave = (own0 && !m0_cyc) || (own1 && !m1_cyc);

  assign cyc_sel = own0 ? m0_cyc : (own1 ? m1_cyc : 1'b0);
  assign stb_sel = own0 ? m0_stb : (own1 ? m1_stb : 1'b0);

  assign s_cyc   = cyc_sel && !kill;
  assign s_stb   = stb_sel && !kill;
  assign s_we    = own0 ? m0_we : (own1 ? m1_we : 1'b0);
  assign s_adr   = own0 ? m0_adr : (own1 ? m1_adr : '0);
  assign s_wdata = own0 ? m0_wdata : (own1 ? m1_wdata : '0);

  assign m0_ack   = own0 && m0_stb && s_ack && !kill;
  assign m1_ack   = own1 && m1_stb && s_ack && !kill;
  assign m0_rdata = own0 ? s_rdata : '0;
  assign m1_rdata = own1 ? s_rdata : '0;
  assign m0_err   = own0 && kill;
  assign m1_err   = own1 && kill;

`ifdef WB_ARB_TIMEOUT_EN
  logic [7:0] timer;
  logic [7:0] cnt;
  logic       err_q;
  logic       hit;

  assign hit = s_stb && !s_ack && !leave &&
               (timer == 8'(TIMEOUT - 1));

  // Stall watchdog: one-cycle error strobe after TIMEOUT unacked strobes.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      timer <= 8'd0;
      err_q <= 1'b0;
      cnt   <= 8'd0;
    end else begin
      err_q <= hit;
      if (leave || !s_stb || s_ack || hit)
        timer <= 8'd0;
      else
        timer <= timer + 8'd1;
      if (hit && cnt != 8'hff)
        cnt <= cnt + 8'd1;
    end
  end

  assign kill    = err_q;
  assign err_cnt = cnt;
`else
  assign kill    = 1'b0;
  assign err_cnt = 8'd0;
`endif

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Two-master Wishbone classic arbiter for sharing one slave port, such as the SRAM adapter path, between masters m0 and m1.
- Uses round-robin arbitration. A grant is held for the full master `cyc` tenure.
- Optionally runs a bus-timeout watchdog that terminates stalled cycles with an error strobe.
- Sits between the SoC masters and the interconnect slave port.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, cycles of `s_stb` without `s_ack` before error termination (legal range 2..255)

Ports:
- clk  in  1  system clock, all logic on rising edge
- RESET_N  in  1  asynchronous active-low reset
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 bus cycle, strobe, write enable
- m0_adr  in  AW  master 0 address
- m0_wdata  in  DW  master 0 write data
- m0_rdata  out  DW  master 0 read data
- m0_ack  out  1  master 0 acknowledge
- m0_err  out  1  master 0 error termination
- m1_*  same set as m0_*, for master 1
- s_cyc, s_stb, s_we  out  1 each  slave bus cycle, strobe, write enable
- s_adr  out  AW  slave address
- s_wdata  out  DW  slave write data
- s_rdata  in  DW  slave read data
- s_ack  in  1  slave acknowledge
- grant  out  2  one-hot current owner: bit0 = m0, bit1 = m1
- err_cnt  out  8  saturating count of timeout events

Behaviour:
- States: IDLE, GNT0, GNT1, with a 1-bit `last` pointer.
- Reset (asynchronous, effective immediately):
  - state = IDLE, `last` = 1, so m0 wins the first tie.
  - grant = 0, err_cnt = 0, timer = 0.
  - All `s_*` outputs and all `m*_ack`, `m*_err`, `m*_rdata` are 0.
- Transitions from IDLE:
  - m0_cyc & m1_cyc: go to GNT(~last).
  - Only one `cyc` high: go to that master's GNT.
  - Otherwise stay in IDLE.
- Transitions from GNTx:
  - Stay while mx_cyc = 1.
  - When mx_cyc = 0: go to IDLE and set last = x.
  - There is always exactly one IDLE cycle between tenures, including when the other master is already waiting.
- Latency: a request seen in cycle N is granted (state registered) at N+1. Slave outputs are driven from N+1.
- Datapath in GNTx (combinational from the registered state):
  - `s_cyc`/`s_stb`/`s_we`/`s_adr`/`s_wdata` = mx_*.
  - mx_ack = s_ack & mx_stb.
  - mx_rdata = s_rdata.
- Non-owner handling:
  - The non-owner sees ack = 0, err = 0, rdata = 0.
  - In IDLE, all `s_*` outputs are 0.
- No preemption: an owner holding `cyc` keeps the bus indefinitely (locked cycle semantics).
- A `s_ack` arriving in IDLE, or with `s_stb` = 0, is ignored.
- `grant` mirrors state: IDLE = 2'b00, GNT0 = 2'b01, GNT1 = 2'b10.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - The timer increments each cycle that `s_stb` = 1 and `s_ack` = 0. It clears on `s_ack`, on state change, or when `s_stb` = 0.
  - When timer == TIMEOUT-1 with no `s_ack`, the next cycle is the error cycle:
    - mx_err = 1 for exactly one cycle.
    - `s_stb` and `s_cyc` are forced to 0 for that cycle.
    - The timer clears.
    - err_cnt increments, saturating at 255.
  - The grant persists until the master drops `cyc`.
  - `s_ack` in the error cycle is ignored.
- Undefined: no timer is built, `m*_err` is tied to 0, and err_cnt is tied to 0.

Test Plan:
- Single master: m0 read of addr 0x10, slave acks 2 cycles after `s_stb` with 0xDEADBEEF.
  - Expect grant = 01 one cycle after m0_cyc.
  - Expect m0_rdata = 0xDEADBEEF with m0_ack.
  - Expect m1_ack = 0 throughout.
- Simultaneous `cyc` from reset: expect m0 granted first. After m0 drops `cyc`, expect one IDLE cycle, then grant = 10.
- Back-to-back contention, both masters holding `cyc` over 4 tenures: expect the grant order 0, 1, 0, 1.
- m1 write of 0x55AA to 0x20 while m0 is requesting: expect `s_we` = 1, `s_wdata` = 0x55AA, and `s_adr` = 0x20 only during GNT1. Expect m0 to see no ack.
- With WB_ARB_TIMEOUT_EN and TIMEOUT = 16, slave never acks an m0 strobe:
  - Expect m0_err pulse in the 17th cycle after `s_stb` rose, with `s_stb` = 0 that cycle.
  - Expect err_cnt = 1.
  - Repeat 300 times and expect err_cnt = 255.
- Assert RESET_N low mid-tenure (GNT1 with `s_stb` high): expect grant = 00, `s_cyc` = 0, and err_cnt = 0 immediately, without waiting for a clock edge.
